command_issue_scheduler: RTL and testbench



---
 rtl/command_issue_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_command_issue_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_issue_scheduler.sv
// command_issue_scheduler: arbitrates NUM_REQ command requesters onto the single
// PSL command port. Each issued command takes the lowest free tag and one PSL
// credit. Responses retire tags and return (signed) credits. Enable/drain
// sequencing lets the AFU shut down only once every command has been answered.
//
// Ports:
//   clock, rstn          clock, asynchronous active-low reset
//   enabled_in           AFU enable (registered before use)
//   init_credits         PSL credit allowance, loaded on INIT; also the credit ceiling
//   req_valid / grant    per-requester pending command / one-hot combinational grant
//   cmd_valid/_tag/_req_id  registered issue strobe, assigned tag, granted requester
//   rsp_valid/_tag/_credits response stream (tag retire + signed credit return)
//   credits, outstanding current credits, tags in flight
//   drained              one-cycle pulse when DRAIN completes
//   error                [1] credit overflow (clamped), [0] response for unknown/free tag
module command_issue_scheduler #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned NUM_TAGS = 32,
    parameter int unsigned CREDIT_W = 9
) (
    input  logic                         clock,
    input  logic                         rstn,
    input  logic                         enabled_in,
    input  logic [7:0]                   init_credits,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         cmd_valid,
    output logic [7:0]                   cmd_tag,
    output logic [$clog2(NUM_REQ)-1:0]   cmd_req_id,
    input  logic                         rsp_valid,
    input  logic [7:0]                   rsp_tag,
    input  logic [CREDIT_W-1:0]          rsp_credits,
    output logic [CREDIT_W-1:0]          credits,
    output logic [$clog2(NUM_TAGS):0]    outstanding,
    output logic                         drained,
    output logic [1:0]                   error
);

    localparam int unsigned REQ_W = $clog2(NUM_REQ);
    localparam int unsigned TAG_W = $clog2(NUM_TAGS);
    localparam int unsigned OUT_W = TAG_W + 1;
    // Two guard bits: credits + returned credits can exceed the signed CREDIT_W range.
    localparam int unsigned SUM_W = CREDIT_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    en;
    logic [REQ_W-1:0]        ptr;
    logic [NUM_TAGS-1:0]     tag_busy;

    logic                    found;
    logic [REQ_W-1:0]        cand;
    logic [REQ_W-1:0]        win_idx;
    logic                    tag_avail;
    logic [TAG_W-1:0]        free_idx;
    logic                    credit_pos;
    logic                    issue;
    logic                    rsp_act;
    logic                    rsp_in_range;
    logic                    rsp_hit;
    logic [TAG_W-1:0]        rsp_idx;
    logic signed [SUM_W-1:0] credit_sum;
    logic signed [SUM_W-1:0] credit_cap;
    logic                    ovf;
    logic [CREDIT_W-1:0]     credits_nxt;
    logic [OUT_W-1:0]        outstanding_nxt;
    logic [NUM_TAGS-1:0]     tag_busy_nxt;
    logic [1:0]              error_nxt;
    logic                    drained_nxt;

    // State register
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (en)                 state_nxt = ST_INIT;
            ST_INIT:                          state_nxt = ST_RUN;
            ST_RUN:   if (!en)                state_nxt = ST_DRAIN;
            ST_DRAIN: if (outstanding == '0)  state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: combinational grant and the next value of the drain pulse
    always_comb begin
        grant       = '0;
        drained_nxt = 1'b0;
        if (issue) grant[win_idx] = 1'b1;
        if (state == ST_DRAIN && outstanding == '0) drained_nxt = 1'b1;
    end

    // Round-robin pick: first pending requester at or after ptr
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = REQ_W'((int'(ptr) + k) % int'(NUM_REQ));
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Lowest-index free tag; uses this cycle's busy map so a tag retired now waits a cycle
    always_comb begin
        tag_avail = 1'b0;
        free_idx  = '0;
        for (int t = int'(NUM_TAGS) - 1; t >= 0; t--) begin
            if (!tag_busy[TAG_W'(t)]) begin
                tag_avail = 1'b1;
                free_idx  = TAG_W'(t);
            end
        end
    end

    // Issue, response retire and credit accounting
    always_comb begin
        credit_pos   = !credits[CREDIT_W-1] && (|credits);
        issue        = (state == ST_RUN) && credit_pos && tag_avail && found;
        rsp_act      = rsp_valid && (state == ST_RUN || state == ST_DRAIN);
        rsp_in_range = (32'(rsp_tag) < NUM_TAGS);
        rsp_idx      = TAG_W'(rsp_tag);
        rsp_hit      = rsp_act && rsp_in_range && tag_busy[rsp_idx];

        credit_sum = {{2{credits[CREDIT_W-1]}}, credits}
                   - (issue ? SUM_W'(1) : SUM_W'(0))
                   + (rsp_act ? {{2{rsp_credits[CREDIT_W-1]}}, rsp_credits} : SUM_W'(0));
        credit_cap = {{(SUM_W-8){1'b0}}, init_credits};
        ovf        = rsp_act && (credit_sum > credit_cap);
        credits_nxt = ovf ? CREDIT_W'(credit_cap) : CREDIT_W'(credit_sum);

        outstanding_nxt = outstanding;
        if (issue && !rsp_hit)      outstanding_nxt = outstanding + OUT_W'(1);
        else if (!issue && rsp_hit) outstanding_nxt = outstanding - OUT_W'(1);

        tag_busy_nxt = tag_busy;
        if (rsp_hit) tag_busy_nxt[rsp_idx]  = 1'b0;
        if (issue)   tag_busy_nxt[free_idx] = 1'b1;

        error_nxt = {ovf, rsp_act && !rsp_hit};
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            en          <= 1'b0;
            ptr         <= '0;
            tag_busy    <= '0;
            cmd_valid   <= 1'b0;
            cmd_tag     <= '0;
            cmd_req_id  <= '0;
            credits     <= '0;
            outstanding <= '0;
            drained     <= 1'b0;
            error       <= '0;
        end else begin
            en        <= enabled_in;
            cmd_valid <= issue;
            drained   <= drained_nxt;
            error     <= error_nxt;
            if (issue) begin
                cmd_tag    <= 8'(free_idx);
                cmd_req_id <= win_idx;
            end
            if (state == ST_INIT) begin
                credits     <= CREDIT_W'(init_credits);
                tag_busy    <= '0;
                outstanding <= '0;
                ptr         <= '0;
            end else begin
                credits     <= credits_nxt;
                tag_busy    <= tag_busy_nxt;
                outstanding <= outstanding_nxt;
                if (issue) ptr <= (win_idx == REQ_W'(NUM_REQ - 1)) ? '0 : win_idx + REQ_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_command_issue_scheduler.sv
// Bench for command_issue_scheduler: directed scenarios plus a randomized phase,
// every cycle compared against a behavioural model of tags, credits and phases.
module tb_command_issue_scheduler;

    localparam int NUM_REQ  = 4;
    localparam int NUM_TAGS = 32;
    localparam int P_IDLE = 0, P_INIT = 1, P_RUN = 2, P_DRAIN = 3;

    logic        clock;
    logic        rstn;
    logic        enabled_in;
    logic [7:0]  init_credits;
    logic [3:0]  req_valid;
    logic [3:0]  grant;
    logic        cmd_valid;
    logic [7:0]  cmd_tag;
    logic [1:0]  cmd_req_id;
    logic        rsp_valid;
    logic [7:0]  rsp_tag;
    logic [8:0]  rsp_credits;
    logic [8:0]  credits;
    logic [5:0]  outstanding;
    logic        drained;
    logic [1:0]  error;

    command_issue_scheduler #(.NUM_REQ(4), .NUM_TAGS(32), .CREDIT_W(9)) dut (
        .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .init_credits(init_credits),
        .req_valid(req_valid), .grant(grant), .cmd_valid(cmd_valid), .cmd_tag(cmd_tag),
        .cmd_req_id(cmd_req_id), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
        .rsp_credits(rsp_credits), .credits(credits), .outstanding(outstanding),
        .drained(drained), .error(error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int drained_count = 0;

    // Behavioural model
    int   m_phase;
    bit   m_en;
    int   m_credits;
    bit   m_busy[NUM_TAGS];
    int   m_ptr;
    bit   e_valid;
    int   e_tag;
    int   e_req;
    int   e_err;
    bit   e_drained;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic int busy_count();
        int n = 0;
        foreach (m_busy[i]) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < NUM_TAGS; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_en = 0; m_credits = 0; m_ptr = 0;
        foreach (m_busy[i]) m_busy[i] = 0;
        e_valid = 0; e_tag = 0; e_req = 0; e_err = 0; e_drained = 0;
    endtask

    // One clock: drive at negedge, check grant, then check registered outputs after the edge
    task automatic cycle(input logic [3:0] rv, input logic rvld, input logic [7:0] rtag,
                         input logic [8:0] rc);
        int  g, ft, nc;
        bit  act, hit, ovf, done;
        logic [8:0] ec;
        @(negedge clock);
        req_valid = rv; rsp_valid = rvld; rsp_tag = rtag; rsp_credits = rc;
        #1;
        g = -1;
        if (m_phase == P_RUN && m_credits > 0 && lowest_free() >= 0)
            for (int k = 0; k < NUM_REQ; k++)
                if (g < 0 && rv[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
        check("grant", 32'(grant), (g >= 0) ? (32'd1 << g) : 32'd0);
        @(posedge clock);
        #1;
        act  = rvld && (m_phase == P_RUN || m_phase == P_DRAIN);
        hit  = act && (int'(rtag) < NUM_TAGS) && m_busy[rtag];
        done = (m_phase == P_DRAIN) && (busy_count() == 0);
        ft   = lowest_free();
        nc   = m_credits;
        e_valid = (g >= 0);
        if (g >= 0) begin
            nc--; m_busy[ft] = 1; e_tag = ft; e_req = g; m_ptr = (g + 1) % NUM_REQ;
        end
        if (act) nc += int'($signed(rc));
        ovf = act && (nc > int'(init_credits));
        if (ovf) nc = int'(init_credits);
        if (hit) m_busy[rtag] = 0;
        e_err = {30'd0, ovf, act && !hit};
        m_credits = nc;
        e_drained = done;
        case (m_phase)
            P_IDLE:  if (m_en) m_phase = P_INIT;
            P_INIT:  begin
                m_credits = int'(init_credits); m_ptr = 0;
                foreach (m_busy[i]) m_busy[i] = 0;
                m_phase = P_RUN;
            end
            P_RUN:   if (!m_en) m_phase = P_DRAIN;
            default: if (done) m_phase = P_IDLE;
        endcase
        m_en = enabled_in;
        if (drained === 1'b1) drained_count++;
        ec = 9'(m_credits);
        check("cmd_valid", 32'(cmd_valid), 32'(e_valid));
        check("cmd_tag", 32'(cmd_tag), 32'(e_tag));
        check("cmd_req_id", 32'(cmd_req_id), 32'(e_req));
        check("credits", 32'(credits), 32'(ec));
        check("outstanding", 32'(outstanding), 32'(busy_count()));
        check("drained", 32'(drained), 32'(e_drained));
        check("error", 32'(error), 32'(e_err));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(4'd0, 1'b0, 8'd0, 9'd0);
    endtask

    task automatic rsp(input int tag, input int c);
        cycle(4'd0, 1'b1, 8'(tag), 9'(c));
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear without a clock edge
    task automatic do_reset();
        @(negedge clock);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_tag", 32'(cmd_tag), 32'd0);
        check("rst_cmd_req_id", 32'(cmd_req_id), 32'd0);
        check("rst_credits", 32'(credits), 32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_drained", 32'(drained), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        model_reset();
        enabled_in = 1'b0; req_valid = '0; rsp_valid = 1'b0;
        @(negedge clock);
        rstn = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic start(input int init);
        init_credits = 8'(init);
        enabled_in   = 1'b1;
        idle(3);
        check("start_credits", 32'(credits), 32'(init));
    endtask

    initial begin
        int q[$];
        int r, c;
        rstn = 1'b0; enabled_in = 1'b0; init_credits = '0; req_valid = '0;
        rsp_valid = 1'b0; rsp_tag = '0; rsp_credits = '0;
        model_reset();
        do_reset();

        // Basic issue/retire with two credits
        start(2);
        cycle(4'b0001, 1'b0, 8'd0, 9'd0);
        check("basic_tag0", 32'(cmd_tag), 32'd0);
        check("basic_cred1", 32'(credits), 32'd1);
        cycle(4'b0001, 1'b0, 8'd0, 9'd0);
        check("basic_tag1", 32'(cmd_tag), 32'd1);
        check("basic_cred0", 32'(credits), 32'd0);
        cycle(4'b0001, 1'b0, 8'd0, 9'd0);
        check("basic_stall", 32'(cmd_valid), 32'd0);
        rsp(0, 1);
        check("basic_ret_cred", 32'(credits), 32'd1);
        cycle(4'b0001, 1'b0, 8'd0, 9'd0);
        check("basic_reuse_tag0", 32'(cmd_tag), 32'd0);

        // Round-robin fairness
        do_reset();
        start(16);
        for (int i = 0; i < 8; i++) begin
            cycle(4'hF, 1'b0, 8'd0, 9'd0);
            check("rr_req_id", 32'(cmd_req_id), 32'(i % 4));
            check("rr_tag", 32'(cmd_tag), 32'(i));
        end

        // Tag exhaustion
        do_reset();
        start(64);
        repeat (34) cycle(4'($urandom_range(1, 15)), 1'b0, 8'd0, 9'd0);
        check("exhaust_outstanding", 32'(outstanding), 32'd32);
        check("exhaust_no_issue", 32'(cmd_valid), 32'd0);
        rsp(5, 0);
        cycle(4'($urandom_range(1, 15)), 1'b0, 8'd0, 9'd0);
        check("exhaust_tag5", 32'(cmd_tag), 32'd5);

        // Same-cycle issue and retire of tag 3 with one credit
        do_reset();
        start(4);
        repeat (4) cycle(4'b0001, 1'b0, 8'd0, 9'd0);
        rsp(0, 1);
        cycle(4'b0010, 1'b1, 8'd3, 9'd1);
        check("coll_credits", 32'(credits), 32'd1);
        check("coll_outstanding", 32'(outstanding), 32'd3);
        check("coll_tag", 32'(cmd_tag), 32'd0);

        // Response for a free tag
        rsp(9, 0);
        check("err_free_tag", 32'(error), 32'd1);
        check("err_free_outstanding", 32'(outstanding), 32'd3);
        idle(1);

        // Credit overflow at full credits
        do_reset();
        start(8);
        repeat (2) cycle(4'b0100, 1'b0, 8'd0, 9'd0);
        rsp(0, 2);
        check("ovf_full", 32'(credits), 32'd8);
        rsp(1, 5);
        check("ovf_clamp", 32'(credits), 32'd8);
        check("ovf_error", 32'(error), 32'd2);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            q.delete();
            foreach (m_busy[t]) if (m_busy[t]) q.push_back(t);
            r = int'($urandom_range(0, 7));
            c = (r == 0) ? -1 : (r < 4) ? 1 : (r < 6) ? 0 : 2;
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                cycle(4'($urandom), 1'($urandom), 8'(q[$urandom_range(0, q.size() - 1)]), 9'(c));
            else
                cycle(4'($urandom), 1'($urandom), 8'($urandom_range(0, 40)), 9'(c));
        end

        // Drain with three outstanding commands
        do_reset();
        start(16);
        repeat (3) cycle(4'b1000, 1'b0, 8'd0, 9'd0);
        enabled_in = 1'b0;
        idle(2);
        repeat (3) cycle(4'hF, 1'b0, 8'd0, 9'd0);
        check("drain_outstanding", 32'(outstanding), 32'd3);
        drained_count = 0;
        rsp(0, 1);
        rsp(1, 1);
        rsp(2, 1);
        repeat (4) cycle(4'hF, 1'b0, 8'd0, 9'd0);
        check("drain_pulses", 32'(drained_count), 32'd1);
        check("drain_outstanding0", 32'(outstanding), 32'd0);

        // Reset in the middle of RUN
        do_reset();
        start(16);
        repeat (3) cycle(4'hF, 1'b0, 8'd0, 9'd0);
        do_reset();
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
